// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default requester count and byte width.
package uart_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int BYTE_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_CKSUM = 2'd2
  } state_e;
endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: the first set request bit, searching
// upward from the slot just after ptr and wrapping modulo N_REQ.
module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             any
);
  logic [ID_W-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % N_REQ);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding one TX FIFO write port.
// Define UART_TX_CKSUM_EN to append an XOR checksum byte after every packet.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  output logic [BYTE_W-1:0]       fifo_data,
  output logic                    fifo_wr,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy,
  output logic [CNT_W-1:0]        pkt_count
);
  state_e            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   winner;
  logic              any_req;
  logic [BYTE_W-1:0] g_data;
  logic              g_valid, g_last, accept;
`ifdef UART_TX_CKSUM_EN
  logic [BYTE_W-1:0] xor_q, xor_d;
`endif

  uart_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any_req)
  );

  assign g_data  = req_data[grant_q*BYTE_W +: BYTE_W];
  assign g_valid = req_valid[grant_q];
  assign g_last  = req_last[grant_q];
  assign accept  = (state_q == ST_XFER) && g_valid && !fifo_full;

  // Write path is combinational so an accepted byte lands in the FIFO the same cycle.
  always_comb begin
    req_ready = '0;
    fifo_wr   = 1'b0;
    fifo_data = '0;
    case (state_q)
      ST_XFER: begin
        req_ready[grant_q] = !fifo_full;
        fifo_wr            = accept;
        if (accept) fifo_data = g_data;
      end
`ifdef UART_TX_CKSUM_EN
      ST_CKSUM: begin
        fifo_wr = !fifo_full;
        if (!fifo_full) fifo_data = xor_q;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
`ifdef UART_TX_CKSUM_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = winner;
          busy_d  = 1'b1;
          state_d = ST_XFER;
`ifdef UART_TX_CKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      ST_XFER: begin
        if (accept) begin
`ifdef UART_TX_CKSUM_EN
          xor_d = xor_q ^ g_data;
`endif
          if (g_last) begin
            ptr_d = grant_q;
`ifdef UART_TX_CKSUM_EN
            state_d = ST_CKSUM;
`else
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = cnt_q + CNT_W'(1);
`endif
          end
        end
      end
`ifdef UART_TX_CKSUM_EN
      ST_CKSUM: begin
        if (!fifo_full) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= ID_W'(N_REQ - 1);
      busy_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef UART_TX_CKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
`ifdef UART_TX_CKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign pkt_count = cnt_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner
// sequences and a randomized run against a packet-level reference model.
module tb_uart_tx_arbiter;
`ifdef UART_TX_CKSUM_EN
  localparam bit CK = 1'b1;
  localparam int PKT_CYC = 3;
`else
  localparam bit CK = 1'b0;
  localparam int PKT_CYC = 2;
`endif

  logic        clk, rst;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        fifo_full, fifo_wr, busy;
  logic [7:0]  fifo_data;
  logic [1:0]  grant_id;
  logic [15:0] pkt_count;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_data(fifo_data), .fifo_wr(fifo_wr), .grant_id(grant_id),
    .busy(busy), .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] v; logic [7:0] d; logic l; logic f;
    logic wr; logic [7:0] od; logic [3:0] rdy; logic bsy; logic [1:0] g; logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  logic [8:0] dq[4][$];
  logic [8:0] mq[4][$];
  logic [7:0] expq[$];
  logic [7:0] gotq[$];

  initial begin
    int gr[$];
    int cy[$];
    int exp_pkts, ptr, w, cyc;
    logic [8:0] e;
    logic [7:0] x;
    logic [3:0] acc, midpkt;
    bit done, found;

    // requester 2 sends 41,42,43 with a full cycle and a valid stall inside
    tbl.push_back('{4'h4, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 16'd0});
    tbl.push_back('{4'h4, 8'h41, 1'b0, 1'b0, 1'b1, 8'h41, 4'h4, 1'b1, 2'd2, 16'd0});
    tbl.push_back('{4'h4, 8'h42, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 2'd2, 16'd0});
    tbl.push_back('{4'h4, 8'h42, 1'b0, 1'b0, 1'b1, 8'h42, 4'h4, 1'b1, 2'd2, 16'd0});
    tbl.push_back('{4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'h4, 1'b1, 2'd2, 16'd0});
    tbl.push_back('{4'h4, 8'h43, 1'b1, 1'b0, 1'b1, 8'h43, 4'h4, 1'b1, 2'd2, 16'd0});
    if (CK) begin
      tbl.push_back('{4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h40, 4'h0, 1'b1, 2'd2, 16'd0});
      tbl.push_back('{4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd2, 16'd1});
    end else begin
      tbl.push_back('{4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd2, 16'd1});
    end

    // reset state
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_cnt", pkt_count, 0);
    chk("rst_wr", fifo_wr, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[k]) begin
      req_valid = tbl[k].v;
      req_data  = {8'h00, tbl[k].d, 16'h0000};
      req_last  = tbl[k].l ? 4'h4 : 4'h0;
      fifo_full = tbl[k].f;
      @(negedge clk);
      chk($sformatf("tbl%0d_wr", k), fifo_wr, tbl[k].wr);
      chk($sformatf("tbl%0d_data", k), fifo_data, tbl[k].od);
      chk($sformatf("tbl%0d_rdy", k), req_ready, tbl[k].rdy);
      chk($sformatf("tbl%0d_busy", k), busy, tbl[k].bsy);
      chk($sformatf("tbl%0d_grant", k), grant_id, tbl[k].g);
      chk($sformatf("tbl%0d_cnt", k), pkt_count, tbl[k].cnt);
      @(posedge clk);
      #1;
    end

    // asynchronous reset mid-packet while a write is active
    req_valid = 4'h8; req_data = 32'h55000000; req_last = 4'h0;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_wr", fifo_wr, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_wr", fifo_wr, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cnt", pkt_count, 0);
    req_valid = 4'h9;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    chk("post_rst_grant", grant_id, 0);
    chk("post_rst_busy", busy, 1);

    // all four requesters stream single-byte packets
    do_reset();
    req_valid = 4'hF; req_last = 4'hF; req_data = 32'h13121110;
    for (int c = 0; c < 40 && gr.size() < 5; c++) begin
      @(negedge clk);
      if (fifo_wr && req_ready != 0) begin
        gr.push_back(int'(grant_id));
        cy.push_back(c);
        chk("rr_data", fifo_data, 8'h10 + grant_id);
      end
      @(posedge clk); #1;
    end
    chk("rr_count", gr.size(), 5);
    for (int k = 0; k < gr.size(); k++) begin
      chk($sformatf("rr_grant%0d", k), gr[k], k % 4);
      if (k > 0) chk($sformatf("rr_gap%0d", k), cy[k] - cy[k-1], PKT_CYC);
    end

    // requester 1 stalls mid-packet while requester 0 waits
    do_reset();
    req_valid = 4'h2; req_data = 32'h0000B000;
    @(negedge clk); @(posedge clk); #1;
    req_valid = 4'h3; req_data = 32'h0000B0AA; req_last = 4'h1;
    @(negedge clk);
    chk("stall_first_wr", fifo_wr, 1);
    chk("stall_first_data", fifo_data, 8'hB0);
    @(posedge clk); #1;
    req_valid = 4'h1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_wr", fifo_wr, 0);
      chk("stall_grant", grant_id, 1);
      @(posedge clk); #1;
    end
    req_valid = 4'h3; req_data = 32'h0000B1AA; req_last = 4'h3;
    @(negedge clk);
    chk("stall_last_data", fifo_data, 8'hB1);
    @(posedge clk); #1;
    req_valid = 4'h1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (fifo_wr && req_ready != 0) begin
        found = 1;
        chk("after_stall_data", fifo_data, 8'hAA);
        chk("after_stall_grant", grant_id, 0);
      end
      @(posedge clk); #1;
    end
    chk("after_stall_seen", found, 1);

    // randomized packets checked against the packet-level model
    do_reset();
    for (int i = 0; i < 4; i++) begin
      int np, len;
      np = $urandom_range(0, 5);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(1, 5);
        for (int b = 0; b < len; b++) begin
          e = {(b == len - 1), 8'($urandom)};
          dq[i].push_back(e);
          mq[i].push_back(e);
        end
      end
    end
    exp_pkts = 0;
    ptr = 3;
    forever begin
      found = 0; w = 0;
      for (int k = 1; k <= 4; k++)
        if (!found && mq[(ptr + k) % 4].size() > 0) begin found = 1; w = (ptr + k) % 4; end
      if (!found) break;
      x = 8'h00;
      do begin
        e = mq[w].pop_front();
        expq.push_back(e[7:0]);
        x ^= e[7:0];
      end while (!e[8]);
      if (CK) expq.push_back(x);
      ptr = w;
      exp_pkts++;
    end

    midpkt = '0;
    done = 0;
    for (cyc = 0; cyc < 5000 && !done; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (dq[i].size() > 0) begin
          req_valid[i] = !(midpkt[i] && $urandom_range(0, 3) == 0);
          req_data[8*i +: 8] = dq[i][0][7:0];
          req_last[i] = dq[i][0][8];
        end else begin
          req_valid[i] = 1'b0; req_data[8*i +: 8] = 8'h00; req_last[i] = 1'b0;
        end
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      acc = req_valid & req_ready;
      chk("rnd_onehot", $onehot0(req_ready), 1);
      if (fifo_full) begin
        chk("rnd_full_rdy", req_ready, 0);
        chk("rnd_full_wr", fifo_wr, 0);
      end
      if (!fifo_wr) chk("rnd_idle_data", fifo_data, 0);
      else gotq.push_back(fifo_data);
      done = (dq[0].size() + dq[1].size() + dq[2].size() + dq[3].size() == 0) && !busy
             && acc == 0;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
        if (acc[i]) begin
          e = dq[i].pop_front();
          midpkt[i] = !e[8];
        end
    end
    chk("rnd_done", done, 1);
    chk("rnd_len", gotq.size(), expq.size());
    for (int k = 0; k < gotq.size() && k < expq.size(); k++)
      chk($sformatf("rnd_byte%0d", k), gotq[k], expq[k]);
    chk("rnd_pkts", pkt_count, exp_pkts);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
